// File: rtl/lzc_arb_seq.sv
// rtl/lzc_arb_seq.sv - shared iterative leading-zero counter, two round-robin requesters
//
// Purpose:
//   Two requesters offer W-bit words. One word at a time is accepted and
//   normalised by a binary-search shift over L = log2(W) cycles. A single
//   shift/compare stage is shared by all steps. The leading-zero count is
//   returned on one result channel, tagged with the id of the issuing requester.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   req0_valid  requester 0 has a word
//   req0_data   requester 0 operand (W bits)
//   req0_ready  requester 0 word accepted this cycle (combinational, IDLE only)
//   req1_valid  requester 1 has a word
//   req1_data   requester 1 operand (W bits)
//   req1_ready  requester 1 word accepted this cycle (combinational, IDLE only)
//   res_valid   result available; held until res_ready is sampled high
//   res_ready   consumer takes the result
//   res_count   leading-zero count, 0..W (CW bits)
//   res_zero    operand was all zeros (res_count = W)
//   res_id      requester that issued this result

module lzc_arb_seq #(
  parameter int W = 32,
  localparam int L = $clog2(W),
  localparam int CW = L + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  input  logic [W-1:0]  req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [W-1:0]  req1_data,
  output logic          req1_ready,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [CW-1:0] res_count,
  output logic          res_zero,
  output logic          res_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] W_C       = CW'(W);
  localparam logic [L-1:0]  LAST_STEP = L'(L - 1);

  state_t         state;
  state_t         state_nxt;

  logic [W-1:0]   shreg;
  logic [CW-1:0]  cnt;
  logic [L-1:0]   step;
  logic           id;
  logic           last;

  logic           grant0;
  logic           grant1;
  logic           accept;

  logic [L-1:0]   step_inc;
  logic [CW-1:0]  s_amt;
  logic [W-1:0]   top_mask;
  logic           top_zero;
  logic [W-1:0]   shreg_nxt;
  logic [CW-1:0]  cnt_nxt;
  logic           last_step;

  // Round-robin grant, independent of state. With both valid, the requester
  // that was not served last wins; the two grants are mutually exclusive.
  always_comb begin
    grant0 = req0_valid & (~req1_valid | last);
    grant1 = req1_valid & (~req0_valid | ~last);
  end

  assign accept = (state == IDLE) & (grant0 | grant1);

  // One binary-search step. s halves every cycle: W/2, W/4, ..., 1.
  // If the top s bits are all zero they are shifted out and counted.
  always_comb begin
    step_inc  = step + 1'b1;
    s_amt     = W_C >> step_inc;
    top_mask  = ~({W{1'b1}} >> s_amt);
    top_zero  = (shreg & top_mask) == '0;
    shreg_nxt = top_zero ? (shreg << s_amt) : shreg;
    cnt_nxt   = top_zero ? (cnt + s_amt) : cnt;
    last_step = (step == LAST_STEP);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    res_valid  = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = grant0;
        req1_ready = grant1;
      end
      DONE:    res_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath. `last` resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg     <= '0;
      cnt       <= '0;
      step      <= '0;
      id        <= 1'b0;
      last      <= 1'b1;
      res_count <= '0;
      res_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shreg <= grant1 ? req1_data : req0_data;
            cnt   <= '0;
            step  <= '0;
            id    <= grant1;
            last  <= grant1;
          end
        end
        RUN: begin
          shreg <= shreg_nxt;
          cnt   <= cnt_nxt;
          step  <= step_inc;
          // After the final s = 1 step the MSB is set unless the word was
          // zero; a clear MSB adds the last missing zero (count becomes W).
          if (last_step) begin
            res_count <= cnt_nxt + {{(CW-1){1'b0}}, ~shreg_nxt[W-1]};
            res_zero  <= ~shreg_nxt[W-1];
          end
        end
        default: ;
      endcase
    end
  end

  assign res_id = id;

endmodule

// File: tb/tb_lzc_arb_seq.sv
// tb/tb_lzc_arb_seq.sv - self-checking bench for lzc_arb_seq
module tb_lzc_arb_seq;

  localparam int W  = 32;
  localparam int L  = 5;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid = 1'b0;
  logic [W-1:0]  req0_data = '0;
  logic          req0_ready;
  logic          req1_valid = 1'b0;
  logic [W-1:0]  req1_data = '0;
  logic          req1_ready;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [CW-1:0] res_count;
  logic          res_zero;
  logic          res_id;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic model_last = 1'b1;

  lzc_arb_seq #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_count  (res_count),
    .res_zero   (res_zero),
    .res_id     (res_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          id;
    logic [W-1:0]  data;
    logic [CW-1:0] cnt;
    logic          zero;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Leading zeros counted by scanning from the MSB.
  function automatic int ref_lzc(input logic [W-1:0] d);
    int n;
    bit found;
    n = 0;
    found = 0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!found) begin
        if (d[i]) found = 1;
        else n++;
      end
    end
    return n;
  endfunction

  // Issue one word on requester rid, scramble the data after accept,
  // optionally hold off res_ready for `hold` cycles, return the result.
  task automatic issue(input logic rid, input logic [W-1:0] d, input int hold,
                       output logic [CW-1:0] gc, output logic gz, output logic gi);
    int lat;
    int wt;
    @(negedge clk);
    if (rid) begin
      req1_valid = 1'b1;
      req1_data  = d;
    end else begin
      req0_valid = 1'b1;
      req0_data  = d;
    end
    res_ready = (hold == 0);
    #1;
    wt = 0;
    while (!(rid ? req1_ready : req0_ready) && wt < 20) begin
      @(negedge clk);
      #1;
      wt++;
    end
    check("grant_wait", int'(wt < 20), 1);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = ~d;
    req1_data  = ~d;
    lat = 0;
    while (!res_valid && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("latency", lat, L);
    gc = res_count;
    gz = res_zero;
    gi = res_id;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", int'(res_valid), 1);
      check("hold_count", int'(res_count), int'(gc));
    end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("res_drop", int'(res_valid), 0);
    model_last = rid;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[9];
    logic [CW-1:0] gc;
    logic gz, gi;
    logic exp_id;
    int got, prev;

    tbl[0] = '{1'b0, 32'h8000_0000, 6'd0,  1'b0};
    tbl[1] = '{1'b0, 32'h0000_0001, 6'd31, 1'b0};
    tbl[2] = '{1'b0, 32'h0001_0000, 6'd15, 1'b0};
    tbl[3] = '{1'b0, 32'h0000_0000, 6'd32, 1'b1};
    tbl[4] = '{1'b1, 32'h4000_0000, 6'd1,  1'b0};
    tbl[5] = '{1'b1, 32'h0000_FFFF, 6'd16, 1'b0};
    tbl[6] = '{1'b1, 32'h0000_0001, 6'd31, 1'b0};
    tbl[7] = '{1'b0, 32'h7FFF_FFFF, 6'd1,  1'b0};
    tbl[8] = '{1'b1, 32'h0000_0003, 6'd30, 1'b0};

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_res_count", int'(res_count), 0);
    check("rst_res_zero",  int'(res_zero), 0);
    check("rst_res_id",    int'(res_id), 0);
    check("rst_req0_ready", int'(req0_ready), 0);
    check("rst_req1_ready", int'(req1_ready), 0);
    rst_n = 1'b1;
    @(negedge clk);
    // First contention goes to requester 0; drop before the edge.
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check("first_grant_r0", int'(req0_ready), 1);
    check("first_grant_r1", int'(req1_ready), 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Directed table
    for (int i = 0; i < 9; i++) begin
      issue(tbl[i].id, tbl[i].data, i % 3, gc, gz, gi);
      check("tbl_count", int'(gc), int'(tbl[i].cnt));
      check("tbl_zero",  int'(gz), int'(tbl[i].zero));
      check("tbl_id",    int'(gi), int'(tbl[i].id));
    end

    // Contention: both held valid, results alternate with 7-cycle spacing.
    @(negedge clk);
    req0_data  = 32'h0000_FFFF;
    req1_data  = 32'h00FF_0000;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    res_ready  = 1'b1;
    exp_id = ~model_last;
    #1;
    check("cont_ready0", int'(req0_ready), int'(!exp_id));
    check("cont_ready1", int'(req1_ready), int'(exp_id));
    got = 0;
    prev = 0;
    for (int t = 0; t < 80 && got < 4; t++) begin
      @(negedge clk);
      if (res_valid) begin
        check("cont_id", int'(res_id), int'(exp_id));
        check("cont_count", int'(res_count), exp_id ? 8 : 16);
        if (got > 0) check("cont_spacing", cyc - prev, 7);
        prev = cyc;
        exp_id = ~exp_id;
        got++;
        if (got == 4) begin
          req0_valid = 1'b0;
          req1_valid = 1'b0;
        end
      end
    end
    check("cont_results", got, 4);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    model_last = ~exp_id;
    @(negedge clk);

    // Backpressure: result held six cycles with both requesters waiting.
    @(negedge clk);
    res_ready  = 1'b0;
    req0_data  = 32'h0000_0F00;
    req0_valid = 1'b1;
    #1;
    check("bp_accept", int'(req0_ready), 1);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    got = 0;
    while (!res_valid && got < 20) begin
      @(negedge clk);
      got++;
    end
    check("bp_valid_seen", int'(res_valid), 1);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("bp_valid", int'(res_valid), 1);
      check("bp_count", int'(res_count), 20);
      check("bp_id",    int'(res_id), 0);
      check("bp_zero",  int'(res_zero), 0);
      check("bp_ready0", int'(req0_ready), 0);
      check("bp_ready1", int'(req1_ready), 0);
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("bp_released", int'(res_valid), 0);
    check("bp_next_ready1", int'(req1_ready), 1);
    check("bp_next_ready0", int'(req0_ready), 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    model_last = 1'b0;

    // Reset in RUN step 2 with a word from requester 1 in flight.
    @(negedge clk);
    req1_data  = 32'hFFFF_FFFF;
    req1_valid = 1'b1;
    #1;
    check("mid_accept", int'(req1_ready), 1);
    @(posedge clk);
    @(negedge clk);
    req1_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", int'(res_valid), 0);
    check("mid_rst_count", int'(res_count), 0);
    check("mid_rst_zero",  int'(res_zero), 0);
    check("mid_rst_id",    int'(res_id), 0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check("mid_rst_grant0", int'(req0_ready), 1);
    check("mid_rst_grant1", int'(req1_ready), 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_last = 1'b1;
    issue(1'b0, 32'h0000_0100, 0, gc, gz, gi);
    check("post_rst_count", int'(gc), 23);
    check("post_rst_zero",  int'(gz), 0);
    check("post_rst_id",    int'(gi), 0);

    // Randomised cross-check against the scanning reference.
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] d;
      logic rid;
      int r;
      r = $urandom_range(0, 9);
      if (r == 0)      d = '0;
      else if (r == 1) d = 32'h1 << $urandom_range(0, 31);
      else             d = $urandom >> $urandom_range(0, 31);
      if (r >= 2 && d == '0) d = 32'h1;
      rid = 1'($urandom_range(0, 1));
      issue(rid, d, $urandom_range(0, 2), gc, gz, gi);
      check("rnd_count", int'(gc), ref_lzc(d));
      check("rnd_zero",  int'(gz), int'(d == '0));
      check("rnd_id",    int'(gi), int'(rid));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/lzc_arb_seq.md
# lzc_arb_seq

Shared, iterative leading-zero counter for the peripheral's datapath. It accepts W-bit words from two requesters and arbitrates between them round-robin. Each word is normalised by a binary-search shift over log2(W) cycles, using one shared shift/compare stage instead of a full combinational tree. The count is returned on a single result channel tagged with the requester id.

## Interface
- W, default 32: operand width; power of two, W ≥ 4.
- L, derived as log2(W): number of iteration steps (5 for W=32).
- CW, derived as L+1: result width; holds 0..W.

Ports:
- clk  input  1  system clock; everything is on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has a word.
- req0_data  input  W  requester 0 operand.
- req0_ready  output  1  requester 0 word accepted this cycle.
- req1_valid  input  1  requester 1 has a word.
- req1_data  input  W  requester 1 operand.
- req1_ready  output  1  requester 1 word accepted this cycle.
- res_valid  output  1  result available.
- res_ready  input  1  consumer takes the result.
- res_count  output  CW  leading-zero count, 0..W.
- res_zero  output  1  operand was all zeros (res_count = W).
- res_id  output  1  requester that issued this result.

## Operation
- States: IDLE, RUN, DONE.
- IDLE
  - reqX_ready is combinational: high only for the granted requester, and only in IDLE.
  - Grant rule: if exactly one reqX_valid is high, grant it. If both are high, grant the requester that is not `last`.
  - On a handshake, load shreg ← data, cnt ← 0, id ← X, step ← 0, `last` ← X, then go to RUN.
- RUN, one step per cycle, with s = W >> (step+1):
  - If shreg[W-1 -: s] == 0, then shreg ← shreg << s and cnt ← cnt + s.
  - step ← step+1.
  - After the step where s = 1 (step = L-1), go to DONE.
- DONE
  - Set res_count = cnt + (shreg[W-1] ? 0 : 1) and res_zero = ~shreg[W-1]. Register both on entry to DONE.
  - res_valid stays high until res_ready is sampled high.
  - On that edge, go to IDLE.
- Arithmetic: cnt is CW bits wide and never overflows; the maximum before the final correction is W-1.
- Requester data is sampled only on the accept edge; later changes on reqX_data are ignored.
- No requests are accepted outside IDLE; both ready signals stay low in RUN and DONE.

## Timing
- Reset values:
  - state = IDLE, `last` = 1, so req0 wins the first contention.
  - res_valid = 0, res_count = 0, res_zero = 0, res_id = 0.
  - req0_ready and req1_ready follow the IDLE rule, so they are 0 while no valid is asserted.
- Latency: an accept on edge k causes res_valid to rise after edge k+L (k+5 for W=32).
- Throughput: the earliest next accept is in the cycle after the res handshake, giving a minimum period of L+2 cycles per word.
- Outputs res_count, res_zero and res_id are stable while res_valid=1 and res_ready=0.
- Simultaneous valid on both requesters in IDLE: exactly one ready goes high, chosen per the round-robin rule.
- Continuous back-to-back requests from both requesters alternate 0,1,0,1…
- A valid that drops before being granted is not recorded and has no effect on `last`.
- Reset asserted mid-RUN or in DONE: all state clears immediately and asynchronously, and the in-flight result is lost. The first accept after reset release follows the reset grant priority.
- res_ready high while res_valid=0 has no effect.

## Test plan
- Single requests on req0 (W=32), one at a time:
  - 0x80000000 → res_count=0, res_zero=0
  - 0x00000001 → 31
  - 0x00010000 → 15
  - 0x00000000 → res_count=32, res_zero=1
  - In every case res_id=0, and res_valid rises exactly 5 edges after accept.
- Contention: req0 and req1 both held valid with 0x0000FFFF and 0x00FF0000 respectively → grant order 0,1,0,1. Results 16 with id 0 and 8 with id 1, alternating; spacing is 7 cycles with res_ready tied high.
- Backpressure: hold res_ready=0 for 6 cycles in DONE → res_valid and the result stay stable, both reqX_ready stay 0, and no new accept occurs until the cycle after the handshake.
- Data stability: change req1_data on the cycle after accept → the result reflects the originally sampled word only.
- Reset mid-operation: pulse rst_n low at RUN step 2 → all outputs read their reset values at once. After release, a fresh request with 0x00000100 → count 23.
- Randomised cross-check: 1000 random words, with 10% forced to zero and 10% forced to a single set bit → every result matches a reference leading-zero count, and ids match issue order.
